// File: rtl/rr_mux_sched_if.sv
// Scheduler-side bundle: requests, per-requester data, burst length and the grant/serial outputs.
// Requesters own req/in/burst_len; the scheduler owns gnt, select and the serial output.
interface rr_mux_sched_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic [N-1:0]         req;
    logic [N-1:0]         in;
    logic [CW-1:0]        burst_len;
    logic [N-1:0]         gnt;
    logic [$clog2(N)-1:0] s;
    logic                 out;
    logic                 valid;
    logic                 done;
    logic                 busy;

    modport master (
        output req, in, burst_len,
        input  gnt, s, out, valid, done, busy
    );

    modport slave (
        input  req, in, burst_len,
        output gnt, s, out, valid, done, busy
    );
endinterface

// File: rtl/rr_mux_sched.sv
// Round-robin 8:1 bit-mux scheduler; grant 1 cycle after req, data bit 1 cycle after each granted cycle.
// No backpressure: a requester holds req to keep its grant, dropping req[s] ends the grant early.
module rr_mux_sched #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_sched_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len;

    logic          found;
    logic [SW-1:0] idx;
    logic [SW-1:0] cand;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + SW'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus.gnt   <= '0;
            bus.s     <= '0;
            bus.out   <= 1'b0;
            bus.valid <= 1'b0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            len       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.gnt   <= '0;
                    bus.out   <= 1'b0;
                    bus.valid <= 1'b0;
                    bus.done  <= 1'b0;
                    if (found) begin
                        bus.gnt  <= N'(1) << idx;
                        bus.s    <= idx;
                        ptr      <= idx + SW'(1);
                        cnt      <= '0;
                        // A zero length wraps to the full 2^CW via the cnt == len-1 compare.
                        len      <= bus.burst_len;
                        state    <= SERVE;
                        bus.busy <= 1'b1;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                SERVE: begin
                    bus.busy <= 1'b1;
                    if (bus.req[bus.s]) begin
                        bus.out   <= bus.in[bus.s];
                        bus.valid <= 1'b1;
                        cnt       <= cnt + CW'(1);
                        if (cnt == len - CW'(1)) begin
                            bus.gnt  <= '0;
                            bus.done <= 1'b1;
                            state    <= GAP;
                        end
                    end else begin
                        bus.out   <= 1'b0;
                        bus.valid <= 1'b0;
                        bus.gnt   <= '0;
                        bus.done  <= 1'b1;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    bus.gnt   <= '0;
                    bus.out   <= 1'b0;
                    bus.valid <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.gnt   <= '0;
                    bus.out   <= 1'b0;
                    bus.valid <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_mux_sched.sv
// Directed bench for rr_mux_sched: reset, single burst, rotation, pointer skip, early release, 16-cycle burst.
module tb_rr_mux_sched;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rr_mux_sched_if bus ();

    rr_mux_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] g, input logic [2:0] sv,
                       input logic o, input logic v, input logic d, input logic b);
        logic [14:0] obs;
        logic [14:0] exp;
        obs = {bus.gnt, bus.s, bus.out, bus.valid, bus.done, bus.busy};
        exp = {g, sv, o, v, d, b};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed {gnt,s,out,valid,done,busy}=%h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] in_pat;
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.in        = 8'h00;
        bus.burst_len = 4'd0;

        tick();
        tick();
        chk("reset", 8'h00, 3'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("idle_init%0d", i), 8'h00, 3'd0, 0, 0, 0, 0);
        end

        // Single burst to requester 3, data 1,0,1,1.
        bus.req = 8'h08; bus.burst_len = 4'd4; bus.in = 8'h08;
        tick(); chk("sb_grant", 8'h08, 3'd3, 0, 0, 0, 1);
        tick(); chk("sb_d0",    8'h08, 3'd3, 1, 1, 0, 1); bus.in = 8'h00;
        tick(); chk("sb_d1",    8'h08, 3'd3, 0, 1, 0, 1); bus.in = 8'h08;
        tick(); chk("sb_d2",    8'h08, 3'd3, 1, 1, 0, 1);
        tick(); chk("sb_d3",    8'h00, 3'd3, 1, 1, 1, 1); bus.req = 8'h00;
        tick(); chk("sb_gap",   8'h00, 3'd3, 0, 0, 0, 0);
        tick(); chk("sb_idle",  8'h00, 3'd3, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a grant.
        bus.req = 8'h08;
        tick(); chk("ar_grant", 8'h08, 3'd3, 0, 0, 0, 1);
        tick(); chk("ar_d0",    8'h08, 3'd3, 1, 1, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk("ar_async", 8'h00, 3'd0, 0, 0, 0, 0);
        bus.req = 8'h00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("ar_idle%0d", i), 8'h00, 3'd0, 0, 0, 0, 0);
        end

        // Full rotation with everyone requesting, single-cycle bursts.
        in_pat = 8'hAA;
        bus.in = in_pat; bus.req = 8'hFF; bus.burst_len = 4'd1;
        for (int i = 0; i < 9; i++) begin
            int n;
            n = i % 8;
            tick(); chk($sformatf("rr%0d_grant", i), 8'h01 << n, 3'(n), 0, 0, 0, 1);
            tick(); chk($sformatf("rr%0d_gap", i), 8'h00, 3'(n), in_pat[n], 1, 1, 1);
            tick(); chk($sformatf("rr%0d_idle", i), 8'h00, 3'(n), 0, 0, 0, 0);
        end

        // Pointer now at 1: requesters 7 and 0 only.
        bus.req = 8'h81;
        tick(); chk("ps_g7",    8'h80, 3'd7, 0, 0, 0, 1);
        tick(); chk("ps_gap7",  8'h00, 3'd7, 1, 1, 1, 1);
        tick(); chk("ps_idle7", 8'h00, 3'd7, 0, 0, 0, 0);
        tick(); chk("ps_g0",    8'h01, 3'd0, 0, 0, 0, 1);
        tick(); chk("ps_gap0",  8'h00, 3'd0, 0, 1, 1, 1); bus.req = 8'h00;
        tick(); chk("ps_idle0", 8'h00, 3'd0, 0, 0, 0, 0);

        // Early release after three data bits.
        bus.req = 8'h20; bus.burst_len = 4'd8; bus.in = 8'h20;
        tick(); chk("er_grant", 8'h20, 3'd5, 0, 0, 0, 1);
        tick(); chk("er_d0",    8'h20, 3'd5, 1, 1, 0, 1); bus.in = 8'h00;
        tick(); chk("er_d1",    8'h20, 3'd5, 0, 1, 0, 1); bus.in = 8'h20;
        tick(); chk("er_d2",    8'h20, 3'd5, 1, 1, 0, 1); bus.req = 8'h00;
        tick(); chk("er_rel",   8'h00, 3'd5, 0, 0, 1, 1);
        tick(); chk("er_idle",  8'h00, 3'd5, 0, 0, 0, 0);

        // burst_len 0 means 16; a later burst_len change must not shorten it.
        bus.req = 8'h01; bus.in = 8'h01; bus.burst_len = 4'd0;
        tick(); chk("bl_grant", 8'h01, 3'd0, 0, 0, 0, 1);
        bus.burst_len = 4'd2;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) chk($sformatf("bl_d%0d", k), 8'h01, 3'd0, 1, 1, 0, 1);
            else        chk($sformatf("bl_d%0d", k), 8'h00, 3'd0, 1, 1, 1, 1);
        end
        tick(); chk("bl_gap",    8'h00, 3'd0, 0, 0, 0, 0);
        tick(); chk("bl_regrant", 8'h01, 3'd0, 0, 0, 0, 1);
        bus.req = 8'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
